stage3_mem_access_unit: RTL and testbench

Memory-stage data-access engine for the 3-stage pipeline. It consumes the execute→mem latch fields, drives the data-side generic bus, and returns the write-back result (`reg_wdata`, `reg_write`, `rd_m`) to execute and fetch. It handles store lane steering, load sign/zero extension, alignment checking, and multi-cycle bus waits, and it stalls the pipeline while a data access is outstanding.

---
 rtl/stage3_mem_access_unit_if.sv | 24 ++
 rtl/stage3_mem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_stage3_mem_access_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/stage3_mem_access_unit_if.sv
// Data-side generic bus between the memory stage and the data memory.
// Latency: none (wires only); the master holds a request until the slave drops dbus_busy.
// Backpressure: dbus_busy=1 from the slave stretches the request indefinitely.
// Ports: dbus_addr/dbus_wdata/dbus_byte_en/dbus_ren/dbus_wen (master->slave),
//        dbus_rdata/dbus_busy (slave->master).
interface stage3_mem_access_unit_if;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_byte_en;
  logic        dbus_ren;
  logic        dbus_wen;
  logic [31:0] dbus_rdata;
  logic        dbus_busy;

  modport master (
    output dbus_addr, dbus_wdata, dbus_byte_en, dbus_ren, dbus_wen,
    input  dbus_rdata, dbus_busy
  );

  modport slave (
    input  dbus_addr, dbus_wdata, dbus_byte_en, dbus_ren, dbus_wen,
    output dbus_rdata, dbus_busy
  );
endinterface

// File: rtl/stage3_mem_access_unit.sv
// Memory-stage data-access engine: store steering, load extension, alignment check.
// Latency: non-memory ops 0 cycles; aligned accesses accept + 1 REQ (+1 per busy cycle) then RESP.
// Backpressure: mem_stall holds execute/fetch from acceptance until RESP; dbus_busy stretches REQ.
// Ports: CLK/nRST; ex_mem fields (valid_m, mem_ren, mem_wen, funct3, mem_addr, store_data,
//        alu_result, wb_en, rd, flush); dbus (bus master modport); write-back (reg_wdata,
//        reg_write, rd_m); mem_stall; misaligned pulse.
module stage3_mem_access_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        valid_m,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_result,
  input  logic        wb_en,
  input  logic [4:0]  rd,
  input  logic        flush,
  stage3_mem_access_unit_if.master dbus,
  output logic [31:0] reg_wdata,
  output logic        reg_write,
  output logic [4:0]  rd_m,
  output logic        mem_stall,
  output logic        misaligned
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [4:0]  r_rd;
  logic        r_wb_en;
  logic        r_ren;
  logic        r_wen;
  logic        r_killed;
  logic [31:0] r_rdata;

  logic        w_is_mem;
  logic        w_live;
  logic        w_mis;
  logic        w_accept;
  logic        w_req;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_sh;
  logic [31:0] w_ext;

  assign w_is_mem = mem_ren | mem_wen;
  assign w_live   = valid_m & ~flush;

  // funct3[1:0] picks the width; reserved encodings fall into the word case.
  always_comb begin
    w_mis = 1'b0;
    w_be  = 4'b1111;
    w_wd  = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_be = 4'b0001 << mem_addr[1:0];
        w_wd = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_mis = mem_addr[0];
        w_be  = 4'b0011 << mem_addr[1:0];
        w_wd  = {2{store_data[15:0]}};
      end
      default: w_mis = |mem_addr[1:0];
    endcase
  end

  assign w_accept = (r_state == IDLE) & w_live & w_is_mem & ~w_mis;

  // Bring the addressed lane down to bit 0 before extending.
  assign w_sh = dbus.dbus_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = w_sh;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_ext = {24'd0, w_sh[7:0]};
      3'b101:  w_ext = {16'd0, w_sh[15:0]};
      default: w_ext = w_sh;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_rd     <= '0;
      r_wb_en  <= 1'b0;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_killed <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr   <= mem_addr;
            r_funct3 <= funct3;
            r_wdata  <= w_wd;
            r_be     <= w_be;
            r_rd     <= rd;
            r_wb_en  <= wb_en & mem_ren;
            r_ren    <= mem_ren;
            r_wen    <= mem_wen;
            r_killed <= 1'b0;
            r_state  <= REQ;
          end
        end
        REQ: begin
          // A flush cannot abort the bus cycle; remember it for RESP instead.
          if (flush) r_killed <= 1'b1;
          if (!dbus.dbus_busy) begin
            r_rdata <= w_ext;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_killed <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus outputs come only from latched state and are zero outside REQ.
  assign w_req             = (r_state == REQ);
  assign dbus.dbus_addr    = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign dbus.dbus_wdata   = w_req ? r_wdata : 32'd0;
  assign dbus.dbus_byte_en = w_req ? r_be : 4'd0;
  assign dbus.dbus_ren     = w_req & r_ren;
  assign dbus.dbus_wen     = w_req & r_wen;

  always_comb begin
    reg_write  = 1'b0;
    reg_wdata  = alu_result;
    rd_m       = rd;
    mem_stall  = 1'b0;
    misaligned = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_is_mem) begin
          misaligned = w_live & w_mis;
          mem_stall  = w_accept;
        end else begin
          reg_write = valid_m & wb_en & ~flush;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        reg_wdata = r_rdata;
        rd_m      = r_rd;
      end
      RESP: begin
        reg_write = r_wb_en & ~r_killed & ~flush;
        reg_wdata = r_rdata;
        rd_m      = r_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stage3_mem_access_unit.sv
// Bench for stage3_mem_access_unit: directed accesses with a write-back scoreboard.
// Latency: expected write-backs are queued at issue and matched whenever reg_write is seen.
// Backpressure: dbus_busy is held for a per-access number of REQ cycles.
module tb_stage3_mem_access_unit;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        valid_m = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0, wb_en = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] mem_addr = '0, store_data = '0, alu_result = '0;
  logic [4:0]  rd = '0;
  logic [31:0] reg_wdata;
  logic        reg_write, mem_stall, misaligned;
  logic [4:0]  rd_m;

  stage3_mem_access_unit_if bus ();

  stage3_mem_access_unit dut (
    .CLK(CLK), .nRST(nRST), .valid_m(valid_m), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .funct3(funct3), .mem_addr(mem_addr), .store_data(store_data), .alu_result(alu_result),
    .wb_en(wb_en), .rd(rd), .flush(flush), .dbus(bus.master), .reg_wdata(reg_wdata),
    .reg_write(reg_write), .rd_m(rd_m), .mem_stall(mem_stall), .misaligned(misaligned)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Every write-back must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (nRST && reg_write) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_wb", 32'd1, 32'd0);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("wb_rd", {27'd0, rd_m}, {27'd0, e[36:32]});
        chk("wb_data", reg_wdata, e[31:0]);
      end
    end
  end

  task automatic idle_inputs();
    valid_m = 0; mem_ren = 0; mem_wen = 0; funct3 = 0; mem_addr = 0; store_data = 0;
    alu_result = 0; wb_en = 0; rd = 0; flush = 0; bus.dbus_busy = 0;
  endtask

  // Presents one instruction from IDLE and follows it until mem_stall drops.
  task automatic mem_op(input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic wb,
                        input logic [4:0] r, input logic [31:0] rdat,
                        input int busy_n, input int flush_at,
                        output int n_stall, output int n_ren, output int n_wen,
                        output logic [3:0] be, output logic [31:0] wd, output logic [31:0] ba,
                        output logic mis, output logic wr);
    int req_seen;
    logic done;
    req_seen = 0; done = 0;
    n_stall = 0; n_ren = 0; n_wen = 0; be = 0; wd = 0; ba = 0; mis = 0; wr = 0;
    valid_m = 1; mem_ren = ren; mem_wen = wen; funct3 = f3; mem_addr = a; store_data = sd;
    alu_result = 32'h1234; wb_en = wb; rd = r; bus.dbus_rdata = rdat;
    bus.dbus_busy = (busy_n > 0); flush = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge CLK);
      if (misaligned) mis = 1;
      if (bus.dbus_ren || bus.dbus_wen) begin
        req_seen++;
        be = bus.dbus_byte_en; wd = bus.dbus_wdata; ba = bus.dbus_addr;
      end
      if (bus.dbus_ren) n_ren++;
      if (bus.dbus_wen) n_wen++;
      if (mem_stall) n_stall++;
      else begin
        wr = reg_write;
        done = 1;
      end
      if (!done) begin
        @(posedge CLK); #1;
        bus.dbus_busy = (req_seen < busy_n);
        flush = (req_seen + 1 == flush_at);
      end
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  int ns, nr, nw;
  logic [3:0] be;
  logic [31:0] wd, ba;
  logic mis, wr;

  initial begin
    idle_inputs();
    bus.dbus_rdata = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ren", {31'd0, bus.dbus_ren}, 0);
    chk("rst_wen", {31'd0, bus.dbus_wen}, 0);
    chk("rst_addr", bus.dbus_addr, 0);
    chk("rst_wdata", bus.dbus_wdata, 0);
    chk("rst_be", {28'd0, bus.dbus_byte_en}, 0);
    chk("rst_stall", {31'd0, mem_stall}, 0);
    chk("rst_wr", {31'd0, reg_write}, 0);
    @(posedge CLK); #1;
    nRST = 1;

    // LB 0x103
    sb_q.push_back({5'd7, 32'hFFFF_FF80});
    mem_op(1, 0, 3'b000, 32'h103, 0, 1, 5'd7, 32'h80FF_1234, 0, 0, ns, nr, nw, be, wd, ba, mis, wr);
    chk("lb_stall", ns, 2);
    chk("lb_ren", nr, 1);
    chk("lb_addr", ba, 32'h100);
    chk("lb_wr", {31'd0, wr}, 1);

    // LH 0x102 back-to-back, sign-extended upper half
    sb_q.push_back({5'd9, 32'hFFFF_80FF});
    mem_op(1, 0, 3'b001, 32'h102, 0, 1, 5'd9, 32'h80FF_1234, 0, 0, ns, nr, nw, be, wd, ba, mis, wr);
    chk("lh_wr", {31'd0, wr}, 1);

    // SH 0x202, busy for 3 cycles
    mem_op(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 1, 5'd3, 0, 3, 0, ns, nr, nw, be, wd, ba, mis, wr);
    chk("sh_wen", nw, 4);
    chk("sh_stall", ns, 5);
    chk("sh_be", {28'd0, be}, 32'hC);
    chk("sh_wdata", wd, 32'hABCD_ABCD);
    chk("sh_addr", ba, 32'h200);
    chk("sh_wr", {31'd0, wr}, 0);

    // SB 0x201
    mem_op(0, 1, 3'b000, 32'h201, 32'h1234_565A, 0, 5'd0, 0, 0, 0, ns, nr, nw, be, wd, ba, mis, wr);
    chk("sb_be", {28'd0, be}, 32'h2);
    chk("sb_wdata", wd, 32'h5A5A_5A5A);

    // LW 0x301 misaligned
    mem_op(1, 0, 3'b010, 32'h301, 0, 1, 5'd4, 32'hFFFF_FFFF, 0, 0, ns, nr, nw, be, wd, ba, mis, wr);
    chk("lw_mis", {31'd0, mis}, 1);
    chk("lw_mis_ren", nr, 0);
    chk("lw_mis_stall", ns, 0);
    chk("lw_mis_wr", {31'd0, wr}, 0);
    @(negedge CLK);
    chk("mis_pulse_off", {31'd0, misaligned}, 0);
    @(posedge CLK); #1;

    // LHU 0x400 flushed in second REQ cycle
    mem_op(1, 0, 3'b101, 32'h400, 0, 1, 5'd6, 32'h0000_8001, 2, 2, ns, nr, nw, be, wd, ba, mis, wr);
    chk("flush_ren", nr, 3);
    chk("flush_wr", {31'd0, wr}, 0);
    @(negedge CLK);
    chk("flush_idle_stall", {31'd0, mem_stall}, 0);
    chk("flush_idle_ren", {31'd0, bus.dbus_ren}, 0);
    @(posedge CLK); #1;

    // ADD pass-through
    sb_q.push_back({5'd5, 32'h0000_1234});
    mem_op(0, 0, 3'b000, 0, 0, 1, 5'd5, 0, 0, 0, ns, nr, nw, be, wd, ba, mis, wr);
    chk("add_wr", {31'd0, wr}, 1);
    chk("add_stall", ns, 0);

    // Reserved funct3 011 load behaves as LW
    sb_q.push_back({5'd11, 32'hCAFE_F00D});
    mem_op(1, 0, 3'b011, 32'h10, 0, 1, 5'd11, 32'hCAFE_F00D, 0, 0, ns, nr, nw, be, wd, ba, mis, wr);
    chk("rsv_wr", {31'd0, wr}, 1);

    // Reset during REQ
    valid_m = 1; mem_ren = 1; funct3 = 3'b010; mem_addr = 32'h500; wb_en = 1; rd = 5'd8;
    bus.dbus_busy = 1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pre_rst_ren", {31'd0, bus.dbus_ren}, 1);
    #1;
    nRST = 0;
    idle_inputs();
    @(posedge CLK); #1;
    chk("mid_rst_ren", {31'd0, bus.dbus_ren}, 0);
    chk("mid_rst_addr", bus.dbus_addr, 0);
    chk("mid_rst_stall", {31'd0, mem_stall}, 0);
    chk("mid_rst_wr", {31'd0, reg_write}, 0);
    nRST = 1;
    @(posedge CLK); #1;

    // LBU 0x001 after reset
    sb_q.push_back({5'd12, 32'h0000_0080});
    mem_op(1, 0, 3'b100, 32'h001, 0, 1, 5'd12, 32'h0000_8000, 0, 0, ns, nr, nw, be, wd, ba, mis, wr);
    chk("lbu_wr", {31'd0, wr}, 1);
    chk("lbu_addr", ba, 32'h0);

    repeat (2) @(posedge CLK);
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
